// File: rtl/search_stack_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// search_stack_ctrl_pkg
//   Shared definitions for the backtracking-search call stack:
//     - pos_e     : 5-bit position codes stored in each frame
//     - frame_t   : packed recursion frame {pos, i, z, k, l} (FRAME_W bits)
//     - MASK_*    : field write masks for the frame register file
//     - state_e   : controller FSM states
//     - make_frame: helper to assemble a frame from its fields
// ----------------------------------------------------------------------------
package search_stack_ctrl_pkg;

    typedef enum logic [4:0] {
        POS_NONE        = 5'd0,
        POS_STOP_1      = 5'd1,
        POS_STOP_2      = 5'd2,
        POS_A_INSERTION = 5'd3,
        POS_C_INSERTION = 5'd4,
        POS_G_INSERTION = 5'd5,
        POS_T_INSERTION = 5'd6,
        POS_A_DELETION  = 5'd7,
        POS_C_DELETION  = 5'd8,
        POS_G_DELETION  = 5'd9,
        POS_T_DELETION  = 5'd10,
        POS_A_SNP       = 5'd11,
        POS_C_SNP       = 5'd12,
        POS_G_SNP       = 5'd13,
        POS_T_SNP       = 5'd14
    } pos_e;

    // Frame layout {pos[36:32], i[31:24], z[23:16], k[15:8], l[7:0]}.
    // i and z are stored bit-exact; -1 appears as 8'hFF.
    typedef struct packed {
        logic [4:0] pos;
        logic [7:0] i;
        logic [7:0] z;
        logic [7:0] k;
        logic [7:0] l;
    } frame_t;

    localparam int FRAME_W = $bits(frame_t);

    localparam logic [FRAME_W-1:0] MASK_POS = {5'h1F, 32'h0000_0000};
    localparam logic [FRAME_W-1:0] MASK_ALL = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ERR
    } state_e;

    function automatic frame_t make_frame(input logic [4:0] pos,
                                          input logic [7:0] i,
                                          input logic [7:0] z,
                                          input logic [7:0] k,
                                          input logic [7:0] l);
        frame_t f;
        f.pos = pos;
        f.i   = i;
        f.z   = z;
        f.k   = k;
        f.l   = l;
        return f;
    endfunction

endpackage

// File: rtl/search_stack_ctrl_if.sv
// ----------------------------------------------------------------------------
// search_stack_ctrl_if
//   Bundle between the call-stack controller and the search pipeline.
//   master : the stack controller (presents frames, hits, status)
//   slave  : the pipeline side (start/root, frame_ready, ex decisions)
//   Groups:
//     root    : start, i0, z0, k0, l0
//     frame   : frame_valid/frame_ready, position_out, i_out, z_out, k_out, l_out
//     decision: ex_valid, over_1, over_2, finish, en_new_position, new_position,
//               new_call, i_new, z_new, k_new, l_new
//     status  : hit_valid, hit_k, hit_l, depth, busy, done, overflow
// ----------------------------------------------------------------------------
interface search_stack_ctrl_if #(
    parameter int DEPTH_W = 5
);

    logic               start;
    logic [7:0]         i0;
    logic [7:0]         z0;
    logic [7:0]         k0;
    logic [7:0]         l0;

    logic               frame_valid;
    logic               frame_ready;
    logic [4:0]         position_out;
    logic [7:0]         i_out;
    logic [7:0]         z_out;
    logic [7:0]         k_out;
    logic [7:0]         l_out;

    logic               ex_valid;
    logic               over_1;
    logic               over_2;
    logic               finish;
    logic               en_new_position;
    logic [4:0]         new_position;
    logic               new_call;
    logic [7:0]         i_new;
    logic [7:0]         z_new;
    logic [7:0]         k_new;
    logic [7:0]         l_new;

    logic               hit_valid;
    logic [7:0]         hit_k;
    logic [7:0]         hit_l;
    logic [DEPTH_W:0]   depth;
    logic               busy;
    logic               done;
    logic               overflow;

    modport master (
        input  start, i0, z0, k0, l0,
        input  frame_ready,
        input  ex_valid, over_1, over_2, finish, en_new_position, new_position,
        input  new_call, i_new, z_new, k_new, l_new,
        output frame_valid, position_out, i_out, z_out, k_out, l_out,
        output hit_valid, hit_k, hit_l, depth, busy, done, overflow
    );

    modport slave (
        output start, i0, z0, k0, l0,
        output frame_ready,
        output ex_valid, over_1, over_2, finish, en_new_position, new_position,
        output new_call, i_new, z_new, k_new, l_new,
        input  frame_valid, position_out, i_out, z_out, k_out, l_out,
        input  hit_valid, hit_k, hit_l, depth, busy, done, overflow
    );

endinterface

// File: rtl/search_frame_stack.sv
// ----------------------------------------------------------------------------
// search_frame_stack
//   DEPTH x FRAME_W register file holding the recursion frames.
//   Ports:
//     clk                         clock
//     i_upd_we/addr/mask/data     masked write port (parent position rewrite)
//     i_push_we/addr/mask/data    masked write port (root / child push)
//     i_rd_addr, o_rd_data        asynchronous read of the top slot
//   Both write ports may fire at the same edge (parent update + child push
//   target adjacent slots). On an address collision the push port wins.
// ----------------------------------------------------------------------------
module search_frame_stack
    import search_stack_ctrl_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_upd_we,
    input  logic [ADDR_W-1:0]  i_upd_addr,
    input  logic [FRAME_W-1:0] i_upd_mask,
    input  frame_t             i_upd_data,
    input  logic               i_push_we,
    input  logic [ADDR_W-1:0]  i_push_addr,
    input  logic [FRAME_W-1:0] i_push_mask,
    input  frame_t             i_push_data,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output frame_t             o_rd_data
);

    frame_t r_mem [DEPTH];

    // NOTE: the storage array has no reset; slots above the depth pointer are
    // never read, so clearing them would only cost flops and reset fanout.
    always_ff @(posedge clk) begin
        if (i_upd_we) begin
            r_mem[i_upd_addr] <= frame_t'((r_mem[i_upd_addr] & ~i_upd_mask) |
                                          (i_upd_data & i_upd_mask));
        end
        if (i_push_we) begin
            r_mem[i_push_addr] <= frame_t'((r_mem[i_push_addr] & ~i_push_mask) |
                                           (i_push_data & i_push_mask));
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/search_stack_ctrl.sv
// ----------------------------------------------------------------------------
// search_stack_ctrl
//   Call-stack controller for the inexact-match backtracking search.
//   Presents the top frame to the fetch/ex pipeline, applies one ex decision
//   per presented frame (pop / position rewrite / push), and reports hits,
//   completion and overflow.
//   Ports:
//     clk    clock
//     rst_n  synchronous reset, active-low
//     bus    search_stack_ctrl_if.master (root, frame, decision, status groups)
// ----------------------------------------------------------------------------
module search_stack_ctrl
    import search_stack_ctrl_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    search_stack_ctrl_if.master bus
);

    localparam int              DEPTH_W    = $clog2(DEPTH);
    localparam logic [DEPTH_W:0] DEPTH_FULL = (DEPTH_W+1)'(DEPTH);
    localparam logic [DEPTH_W:0] DEPTH_ONE  = (DEPTH_W+1)'(1);

    state_e             r_state;
    logic [DEPTH_W:0]   r_depth;
    logic               r_frame_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_hit_valid;
    logic [7:0]         r_hit_k;
    logic [7:0]         r_hit_l;
    logic               r_overflow;

    logic               w_root;
    logic               w_decide;
    logic               w_pop;
    logic               w_upd;
    logic               w_call;
    logic               w_full;
    logic               w_push;
    logic [DEPTH_W:0]   w_depth_m1;
    logic [DEPTH_W-1:0] w_top_addr;
    frame_t             w_top;
    frame_t             w_upd_data;
    logic               w_push_we;
    logic [DEPTH_W-1:0] w_push_addr;
    frame_t             w_push_data;

    // Decision decode. Any termination flag pops and suppresses the
    // position rewrite and the push issued in the same cycle.
    assign w_root     = (r_state == ST_IDLE) && bus.start;
    assign w_decide   = (r_state == ST_WAIT) && bus.ex_valid;
    assign w_pop      = w_decide && (bus.over_1 || bus.over_2 || bus.finish);
    assign w_upd      = w_decide && !w_pop && bus.en_new_position;
    assign w_call     = w_decide && !w_pop && bus.new_call;
    assign w_full     = (r_depth == DEPTH_FULL);
    assign w_push     = w_call && !w_full;

    assign w_depth_m1 = r_depth - DEPTH_ONE;
    assign w_top_addr = w_depth_m1[DEPTH_W-1:0];
    assign w_upd_data = make_frame(bus.new_position, 8'h00, 8'h00, 8'h00, 8'h00);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value held and no latch is inferred.
        w_push_we   = 1'b0;
        w_push_addr = '0;
        w_push_data = '0;
        if (w_root) begin
            w_push_we   = 1'b1;
            w_push_data = make_frame(POS_NONE, bus.i0, bus.z0, bus.k0, bus.l0);
        end else if (w_push) begin
            w_push_we   = 1'b1;
            w_push_addr = r_depth[DEPTH_W-1:0];
            w_push_data = make_frame(POS_NONE, bus.i_new, bus.z_new, bus.k_new, bus.l_new);
        end
    end

    search_frame_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk         (clk),
        .i_upd_we    (w_upd),
        .i_upd_addr  (w_top_addr),
        .i_upd_mask  (MASK_POS),
        .i_upd_data  (w_upd_data),
        .i_push_we   (w_push_we),
        .i_push_addr (w_push_addr),
        .i_push_mask (MASK_ALL),
        .i_push_data (w_push_data),
        .i_rd_addr   (w_top_addr),
        .o_rd_data   (w_top)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_depth       <= '0;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_hit_valid   <= 1'b0;
            r_hit_k       <= '0;
            r_hit_l       <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_hit_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_depth       <= DEPTH_ONE;
                        r_busy        <= 1'b1;
                        r_frame_valid <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // frame_valid is already high here; hold until accepted.
                    if (bus.frame_ready) begin
                        r_frame_valid <= 1'b0;
                        r_state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.ex_valid) begin
                        if (w_pop) begin
                            if (!bus.over_1 && bus.over_2) begin
                                r_hit_valid <= 1'b1;
                                r_hit_k     <= w_top.k;
                                r_hit_l     <= w_top.l;
                            end
                            r_depth <= w_depth_m1;
                            if (r_depth == DEPTH_ONE) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end else begin
                                r_frame_valid <= 1'b1;
                                r_state       <= ST_ISSUE;
                            end
                        end else if (w_call && w_full) begin
                            // Push dropped; the parent rewrite still lands.
                            r_overflow <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= ST_ERR;
                        end else begin
                            if (w_push) begin
                                r_depth <= r_depth + DEPTH_ONE;
                            end
                            r_frame_valid <= 1'b1;
                            r_state       <= ST_ISSUE;
                        end
                    end
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Frame fields read as zero whenever no frame is being presented.
    assign bus.frame_valid  = r_frame_valid;
    assign bus.position_out = r_frame_valid ? w_top.pos : 5'h00;
    assign bus.i_out        = r_frame_valid ? w_top.i   : 8'h00;
    assign bus.z_out        = r_frame_valid ? w_top.z   : 8'h00;
    assign bus.k_out        = r_frame_valid ? w_top.k   : 8'h00;
    assign bus.l_out        = r_frame_valid ? w_top.l   : 8'h00;
    assign bus.hit_valid    = r_hit_valid;
    assign bus.hit_k        = r_hit_k;
    assign bus.hit_l        = r_hit_l;
    assign bus.depth        = r_depth;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.overflow     = r_overflow;

endmodule
